// File: rtl/sdf_bf_stage_64.sv
// sdf_bf_stage_64
//   Radix-2 single-path delay-feedback butterfly stage with a DEPTH-entry
//   feedback delay line. It is one stage of a pipelined FFT. The upstream
//   twiddle generator provides the phase code and the twiddle factor aligned
//   with each input sample.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid            sample present on din_*; the first one starts the stage
//   din_r, din_i        input sample (signed, DW bits)
//   state               phase: 0 fill, 1 butterfly sum, 2 twiddle difference,
//                       3 reserved (treated as fill)
//   w_r, w_i            twiddle factor, FRAC fractional bits (used in phase 2)
//   out_valid           dout_* carries a result this cycle
//   dout_r, dout_i      output sample (signed, DW bits), held when not updated
module sdf_bf_stage_64 #(
  parameter int DW    = 24,
  parameter int FRAC  = 8,
  parameter int DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din_r,
  input  logic signed [DW-1:0] din_i,
  input  logic [1:0]           state,
  input  logic signed [DW-1:0] w_r,
  input  logic signed [DW-1:0] w_i,
  output logic                 out_valid,
  output logic signed [DW-1:0] dout_r,
  output logic signed [DW-1:0] dout_i
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    PH_FILL = 2'd0,
    PH_SUM  = 2'd1,
    PH_TWID = 2'd2,
    PH_RSVD = 2'd3
  } phase_e;

  logic [2*DW-1:0]        r_mem [DEPTH];
  logic [PW-1:0]          r_ptr;
  logic                   r_running;

  phase_e                 w_phase;
  logic                   w_adv;
  logic signed [DW-1:0]   w_h_r;
  logic signed [DW-1:0]   w_h_i;
  logic signed [DW-1:0]   w_sum_r;
  logic signed [DW-1:0]   w_sum_i;
  logic signed [DW-1:0]   w_dif_r;
  logic signed [DW-1:0]   w_dif_i;
  logic signed [2*DW-1:0] w_hr_x;
  logic signed [2*DW-1:0] w_hi_x;
  logic signed [2*DW-1:0] w_wr_x;
  logic signed [2*DW-1:0] w_wi_x;
  logic signed [2*DW-1:0] w_acc_r;
  logic signed [2*DW-1:0] w_acc_i;
  logic signed [DW-1:0]   w_rot_r;
  logic signed [DW-1:0]   w_rot_i;
  logic [2*DW-1:0]        w_wdata;

  assign w_phase = phase_e'(state);

  // Once started the stage advances every cycle, in lock-step with the
  // generator's free-running phase counter.
  assign w_adv = in_valid | r_running;

  // Head of the delay line; read-before-write on the same entry.
  assign {w_h_r, w_h_i} = r_mem[r_ptr];

  assign w_sum_r = w_h_r + din_r;
  assign w_sum_i = w_h_i + din_i;
  assign w_dif_r = w_h_r - din_r;
  assign w_dif_i = w_h_i - din_i;

  // Operands widened to 2*DW so each product is the full signed product.
  assign w_hr_x = {{DW{w_h_r[DW-1]}}, w_h_r};
  assign w_hi_x = {{DW{w_h_i[DW-1]}}, w_h_i};
  assign w_wr_x = {{DW{w_r[DW-1]}}, w_r};
  assign w_wi_x = {{DW{w_i[DW-1]}}, w_i};

  assign w_acc_r = (w_hr_x * w_wr_x) - (w_hi_x * w_wi_x);
  assign w_acc_i = (w_hr_x * w_wi_x) + (w_hi_x * w_wr_x);

  // Arithmetic shift then truncation: rounds toward minus infinity.
  assign w_rot_r = DW'(w_acc_r >>> FRAC);
  assign w_rot_i = DW'(w_acc_i >>> FRAC);

  always_comb begin
    w_wdata = {din_r, din_i};
    if (w_phase == PH_SUM) begin
      w_wdata = {w_dif_r, w_dif_i};
    end
  end

  // Delay memory is not reset: the fill phase overwrites every entry before
  // any of them is read.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_mem[r_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_running <= 1'b0;
      r_ptr     <= '0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      if (in_valid) begin
        r_running <= 1'b1;
      end
      if (w_adv) begin
        r_ptr <= r_ptr + 1'b1;
        case (w_phase)
          PH_SUM: begin
            out_valid <= 1'b1;
            dout_r    <= w_sum_r;
            dout_i    <= w_sum_i;
          end
          PH_TWID: begin
            out_valid <= 1'b1;
            dout_r    <= w_rot_r;
            dout_i    <= w_rot_i;
          end
          default: begin
            out_valid <= 1'b0;
          end
        endcase
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdf_bf_stage_64.sv
// tb_sdf_bf_stage_64
//   Self-checking bench for sdf_bf_stage_64. A generator model drives the
//   phase code and twiddles; a queue-based reference model of the delay
//   stage predicts out_valid/dout every cycle, and directed patterns add
//   fixed expected values at known output positions.
module tb_sdf_bf_stage_64;

  localparam int DW    = 24;
  localparam int FRAC  = 8;
  localparam int DEPTH = 64;
  localparam real PI   = 3.141592653589793;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic signed [DW-1:0] din_r;
  logic signed [DW-1:0] din_i;
  logic [1:0]           state;
  logic signed [DW-1:0] w_r;
  logic signed [DW-1:0] w_i;
  logic                 out_valid;
  logic signed [DW-1:0] dout_r;
  logic signed [DW-1:0] dout_i;

  always #5 clk = ~clk;

  sdf_bf_stage_64 #(
    .DW    (DW),
    .FRAC  (FRAC),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .state     (state),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
  } cpx_t;

  cpx_t          q[$];
  bit            m_run;
  int            gen_n;
  bit            exp_ov;
  logic [DW-1:0] exp_r;
  logic [DW-1:0] exp_i;
  int            tw_r[DEPTH];
  int            tw_i[DEPTH];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // (x0*y0 -/+ x1*y1) >>> FRAC, kept to DW bits.
  function automatic logic [DW-1:0] mac(input logic signed [DW-1:0] x0, input logic signed [DW-1:0] y0,
                                        input logic signed [DW-1:0] x1, input logic signed [DW-1:0] y1,
                                        input bit sub);
    longint     p;
    longint     s;
    longint     t;
    logic [63:0] tt;
    p  = longint'(x0) * longint'(y0);
    s  = longint'(x1) * longint'(y1);
    t  = sub ? (p - s) : (p + s);
    t  = t >>> FRAC;
    tt = t;
    return tt[DW-1:0];
  endfunction

  function automatic logic [1:0] gen_state(input int n);
    if (n < DEPTH) return 2'd0;
    return (((n - DEPTH) / DEPTH) % 2 != 0) ? 2'd2 : 2'd1;
  endfunction

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic cycle(input bit iv, input logic [DW-1:0] dr, input logic [DW-1:0] di, input bit rand_w);
    logic [1:0]    st;
    logic [DW-1:0] wr;
    logic [DW-1:0] wi;
    cpx_t          h;
    cpx_t          x;
    int            k;
    st = gen_state(gen_n);
    if (st == 2'd2 && !rand_w) begin
      k  = (gen_n - DEPTH) % DEPTH;
      wr = DW'(tw_r[k]);
      wi = DW'(tw_i[k]);
    end else begin
      wr = DW'($urandom());
      wi = DW'($urandom());
    end
    in_valid = iv;
    din_r    = dr;
    din_i    = di;
    state    = st;
    w_r      = wr;
    w_i      = wi;

    if (iv || m_run) begin
      x.r = dr;
      x.i = di;
      h   = '0;
      if (q.size() == DEPTH) h = q.pop_front();
      exp_ov = 1'b0;
      case (st)
        2'd1: begin
          exp_ov = 1'b1;
          exp_r  = h.r + dr;
          exp_i  = h.i + di;
          x.r    = h.r - dr;
          x.i    = h.i - di;
        end
        2'd2: begin
          exp_ov = 1'b1;
          exp_r  = mac(h.r, wr, h.i, wi, 1'b1);
          exp_i  = mac(h.r, wi, h.i, wr, 1'b0);
        end
        default: ;
      endcase
      q.push_back(x);
      m_run = m_run | iv;
      gen_n++;
    end else begin
      exp_ov = 1'b0;
    end

    @(posedge clk);
    #1;
    chk("out_valid", {{(DW-1){1'b0}}, out_valid}, {{(DW-1){1'b0}}, exp_ov});
    chk("dout_r", dout_r, exp_r);
    chk("dout_i", dout_i, exp_i);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_out_valid", {{(DW-1){1'b0}}, out_valid}, '0);
    chk("rst_dout_r", dout_r, '0);
    chk("rst_dout_i", dout_i, '0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    q.delete();
    m_run  = 1'b0;
    gen_n  = 0;
    exp_ov = 1'b0;
    exp_r  = '0;
    exp_i  = '0;
  endtask

  // kind: 0 constant, 1 impulse, 2 twiddle, 3 wrap, 4 random
  task automatic run(input int kind, input int stall, input int ncyc, input bit rand_w);
    logic [DW-1:0] dr;
    logic [DW-1:0] di;
    bit            iv;
    for (int s = 0; s < stall; s++) begin
      cycle(1'b0, DW'($urandom()), DW'($urandom()), 1'b0);
    end
    for (int n = 0; n < ncyc; n++) begin
      iv = 1'b1;
      di = '0;
      case (kind)
        0:       dr = DW'(100);
        1:       dr = (n == 0) ? DW'(256) : '0;
        2:       dr = (n < DEPTH) ? DW'(256) : '0;
        3:       dr = 24'h7FFFFF;
        default: begin
          dr = DW'($urandom());
          di = DW'($urandom());
          if (n > 0) iv = 1'($urandom_range(0, 1));
        end
      endcase
      cycle(iv, dr, di, rand_w);
      if (kind == 0 && n == 64)  chk("const_sum", dout_r, DW'(200));
      if (kind == 0 && n == 128) chk("const_dif", dout_r, '0);
      if (kind == 1 && n == 64)  chk("imp_sum", dout_r, DW'(256));
      if (kind == 1 && n == 128) chk("imp_twid", dout_r, DW'(256));
      if (kind == 2 && n == 64)  chk("tw_sum", dout_r, DW'(256));
      if (kind == 2 && n == 160) begin
        chk("tw96_r", dout_r, '0);
        chk("tw96_i", dout_i, 24'hFFFF00);
      end
      if (kind == 2 && n == 176) begin
        chk("tw112_r", dout_r, 24'hFFFF4B);
        chk("tw112_i", dout_i, 24'hFFFF4B);
      end
      if (kind == 3 && n == 64)  chk("wrap_sum", dout_r, 24'hFFFFFE);
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      tw_r[k] = int'(256.0 * $cos(2.0 * PI * k / 128.0));
      tw_i[k] = int'(-256.0 * $sin(2.0 * PI * k / 128.0));
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    din_r    = '0;
    din_i    = '0;
    state    = '0;
    w_r      = '0;
    w_i      = '0;
    m_run    = 1'b0;
    gen_n    = 0;
    #1;
    do_reset();

    run(0, 0, 192, 1'b0);
    do_reset();
    run(1, 0, 192, 1'b0);
    do_reset();
    run(2, 0, 192, 1'b0);
    do_reset();
    run(3, 0, 70, 1'b0);
    do_reset();
    run(0, 10, 192, 1'b0);
    do_reset();
    run(4, 5, 300, 1'b1);
    do_reset();
    run(4, 3, 400, 1'b1);
    do_reset();
    run(4, 0, 200, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
